// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared data-memory constants and SRAM controller state type
package arm_mem_pkg;

   localparam int BASE_ADDR_DEF   = 1024;
   localparam int SRAM_ADDR_W_DEF = 18;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } sram_state_e;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage access split into two 16-bit SRAM phases
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter int BASE_ADDR   = BASE_ADDR_DEF,
   parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
   parameter int HALF_CYCLES = 2
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_we_n
);

   localparam int CNT_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

   sram_state_e            state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [SRAM_ADDR_W-2:0] word_q;
   logic                   wr_q;
   logic [15:0]            wdata_hi_q;
   logic [31:0]            read_data_q;
   logic [SRAM_ADDR_W-1:0] sram_addr_q;
   logic [15:0]            dq_out_q;
   logic                   dq_oe_q;
   logic                   we_n_q;

   logic [31:0]            offset_d;
   logic [SRAM_ADDR_W-2:0] word_d;
   logic                   req;
   logic                   cnt_last;
   logic                   unused_offset_bits;

   // Word index is taken modulo the SRAM size; byte lane bits are dropped.
   assign offset_d           = address - 32'(BASE_ADDR);
   assign word_d             = offset_d[SRAM_ADDR_W:2];
   assign unused_offset_bits = ^{offset_d[31:SRAM_ADDR_W+1], offset_d[1:0]};
   assign req                = wr_en | rd_en;
   assign cnt_last           = (cnt_q == CNT_W'(HALF_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         wr_q        <= 1'b0;
         wdata_hi_q  <= '0;
         read_data_q <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  // Bus outputs are set up here so they are valid from the first LOW cycle.
                  state_q     <= S_LOW;
                  cnt_q       <= '0;
                  word_q      <= word_d;
                  wr_q        <= wr_en;
                  wdata_hi_q  <= write_data[31:16];
                  sram_addr_q <= {word_d, 1'b0};
                  dq_out_q    <= write_data[15:0];
                  dq_oe_q     <= wr_en;
                  we_n_q      <= ~wr_en;
               end
            end
            S_LOW: begin
               if (cnt_last) begin
                  if (!wr_q) read_data_q[15:0] <= sram_dq_in;
                  state_q     <= S_HIGH;
                  cnt_q       <= '0;
                  sram_addr_q <= {word_q, 1'b1};
                  dq_out_q    <= wdata_hi_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_HIGH: begin
               if (cnt_last) begin
                  if (!wr_q) read_data_q[31:16] <= sram_dq_in;
                  state_q <= S_DONE;
                  cnt_q   <= '0;
                  dq_oe_q <= 1'b0;
                  we_n_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready       = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with behavioural SRAM
module tb_sram_controller;
   import arm_mem_pkg::*;

   localparam int AW = SRAM_ADDR_W_DEF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [31:0]   address = '0;
   logic [31:0]   write_data = '0;
   logic [31:0]   read_data;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out;
   logic          sram_dq_oe;
   logic [15:0]   sram_dq_in;
   logic          sram_we_n;

   logic [15:0]   mem [0:(1<<AW)-1];

   typedef struct {
      logic          wr;
      logic [AW-1:0] base;
      logic [31:0]   wdata;
      logic [31:0]   rd;
      logic          abort;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   sram_controller #(.BASE_ADDR(BASE_ADDR_DEF), .SRAM_ADDR_W(AW), .HALF_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   assign sram_dq_in = mem[sram_addr];
   always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: counts cycles of each access and checks bus and result against the scoreboard head.
   initial begin : monitor
      int   c;
      bit   busy;
      logic ph;
      busy = 0;
      c = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (busy) begin
               if (sb_q.size() > 0 && sb_q[0].abort) void'(sb_q.pop_front());
               else chk("unexpected_abort", 32'd1, 32'd0);
            end
            busy = 0;
         end else begin
            if (!busy && !ready) begin
               busy = 1;
               c = 0;
            end else if (busy) begin
               c++;
            end
            if (busy && sb_q.size() == 0) begin
               chk("sb_empty_on_access", 32'd1, 32'd0);
               busy = 0;
            end else if (busy && c >= 1 && c <= 4) begin
               ph = (c > 2);
               chk("ready_low", 32'(ready), 32'd0);
               chk("sram_addr", 32'(sram_addr), 32'(sb_q[0].base | AW'(ph)));
               chk("we_n", 32'(sram_we_n), 32'(!sb_q[0].wr));
               chk("dq_oe", 32'(sram_dq_oe), 32'(sb_q[0].wr));
               if (sb_q[0].wr)
                  chk("dq_out", 32'(sram_dq_out), ph ? 32'(sb_q[0].wdata[31:16]) : 32'(sb_q[0].wdata[15:0]));
            end else if (busy && ready) begin
               chk("done_cycle", c, 5);
               chk("read_data", read_data, sb_q[0].rd);
               chk("done_we_n", 32'(sram_we_n), 32'd1);
               chk("done_dq_oe", 32'(sram_dq_oe), 32'd0);
               chk("done_addr_hold", 32'(sram_addr), 32'(sb_q[0].base | AW'(1)));
               if (sb_q[0].abort) chk("abort_completed", 32'd1, 32'd0);
               void'(sb_q.pop_front());
               busy = 0;
            end
            if (busy && c > 10) begin
               chk("access_timeout", 32'(c), 32'd5);
               busy = 0;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                         input logic [AW-1:0] base, input logic [31:0] exp_rd);
      bit seen;
      sb_q.push_back('{wr: we, base: base, wdata: d, rd: exp_rd, abort: 1'b0});
      @(posedge clk); #1;
      wr_en = we; rd_en = re; address = a; write_data = d;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready) begin
            seen = 1;
            break;
         end
      end
      chk("ready_seen", 32'(seen), 32'd1);
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      wr_en = 0; rd_en = 0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
      chk("rst_read_data", read_data, 32'd0);

      do_req(1, 0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0);
      do_req(0, 1, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
      idle(3);
      chk("read_data_held", read_data, 32'hDEADBEEF);

      do_req(1, 0, 32'd1028, 32'h12345678, 18'd2, 32'hDEADBEEF);
      do_req(0, 1, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
      do_req(0, 1, 32'd1028, 32'h0, 18'd2, 32'h12345678);
      do_req(1, 1, 32'd1032, 32'h0000CAFE, 18'd4, 32'h12345678);
      idle(2);
      chk("both_keeps_read_data", read_data, 32'h12345678);
      do_req(0, 1, 32'd1032, 32'h0, 18'd4, 32'h0000CAFE);
      idle(2);

      sb_q.push_back('{wr: 1'b1, base: 18'd6, wdata: 32'h11112222, rd: 32'h0, abort: 1'b1});
      @(posedge clk); #1;
      wr_en = 1; address = 32'd1036; write_data = 32'h11112222;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1; wr_en = 0;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("abort_addr", 32'(sram_addr), 32'd0);
      chk("abort_dq_out", 32'(sram_dq_out), 32'd0);
      chk("abort_read_data", read_data, 32'd0);
      chk("abort_sb_popped", 32'(sb_q.size()), 32'd0);

      do_req(0, 1, 32'd1026, 32'h0, 18'd0, 32'hDEADBEEF);
      do_req(1, 0, 32'd0, 32'hA5A55A5A, 18'h3FE00, 32'hDEADBEEF);
      do_req(1, 0, 32'd1020, 32'hC3C33C3C, 18'h3FFFE, 32'hDEADBEEF);
      do_req(0, 1, 32'd0, 32'h0, 18'h3FE00, 32'hA5A55A5A);
      do_req(0, 1, 32'd1020, 32'h0, 18'h3FFFE, 32'hC3C33C3C);
      idle(3);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
